// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared constants and helpers for the multi-channel clock
//               divider (default counter width, minimum select width and
//               extraction of per-channel reset divisors).
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam int c_CNT_W_DEFAULT = 32;
    localparam int c_SEL_W_MIN     = 1;

    // Helper limits: up to 16 channels of up to 64-bit counters.
    localparam int c_MAX_CH    = 16;
    localparam int c_MAX_CNT_W = 64;
    localparam int c_FLAT_W    = c_MAX_CH * c_MAX_CNT_W;

    // Return slice idx (cnt_w bits wide) of a flattened divisor vector,
    // zero-extended to c_MAX_CNT_W bits.
    function automatic logic [c_MAX_CNT_W-1:0] div_init_slice(
        input logic [c_FLAT_W-1:0] flat,
        input int                  idx,
        input int                  cnt_w
    );
        logic [c_FLAT_W-1:0]    w_shifted;
        logic [c_MAX_CNT_W-1:0] w_mask;
        w_shifted = flat >> (idx * cnt_w);
        w_mask    = '1;
        if (cnt_w < c_MAX_CNT_W) begin
            w_mask = ~(w_mask << cnt_w);
        end
        return w_shifted[c_MAX_CNT_W-1:0] & w_mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_multi_if
// Description : Control/status bundle of the multi-channel clock divider:
//               enables, restart, divisor write port and per-channel outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = c_CNT_W_DEFAULT,
    parameter int SEL_W  = 2
);

    logic [NUM_CH-1:0] ch_en;
    logic              sync_restart;
    logic              div_wr;
    logic [SEL_W-1:0]  div_sel;
    logic [CNT_W-1:0]  div_data;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] div_pending;

    // Controller side: drives configuration, observes divider outputs.
    modport master (
        output ch_en, sync_restart, div_wr, div_sel, div_data,
        input  clk_out, tick, div_pending
    );

    // Divider side.
    modport slave (
        input  ch_en, sync_restart, div_wr, div_sel, div_data,
        output clk_out, tick, div_pending
    );

endinterface
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_chan
// Description : One divider channel: counter, active/shadow divisor, pending
//               flag and 50%-duty toggle output with a registered tick.
//               Macro CLKDIV_RISE_TICK_EN: tick only on 0->1 toggles.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               CNT_W    = c_CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0] DIV_INIT = CNT_W'(1)
) (
    input  wire logic             clk_in,
    input  wire logic             rst,
    input  wire logic             i_en,
    input  wire logic             i_restart,
    input  wire logic             i_wr,
    input  wire logic [CNT_W-1:0] i_wr_data,
    output logic                  o_clk_out,
    output logic                  o_tick,
    output logic                  o_pending
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_act_div;
    logic [CNT_W-1:0] r_shd_div;
    logic             r_pending;
    logic             r_clk_out;
    logic             r_tick;

    logic w_wrap;
    logic w_apply;
    logic w_tick_evt;

    // The half-period ends when the counter reaches the active divisor; the
    // counter never exceeds act_div so it cannot overflow.
    assign w_wrap  = (r_cnt == r_act_div);

    // Points where no half-period is in flight, so a new divisor is safe.
    assign w_apply = i_restart | ~i_en | w_wrap;

`ifdef CLKDIV_RISE_TICK_EN
    // The wrap toggles clk_out, so it rises exactly when it is currently low.
    assign w_tick_evt = ~r_clk_out;
`else
    assign w_tick_evt = 1'b1;
`endif

    // Divisor shadowing: writes land in the shadow and are promoted only at
    // a safe point; a write coinciding with that point goes straight in.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_act_div <= DIV_INIT;
            r_shd_div <= DIV_INIT;
            r_pending <= 1'b0;
        end else if (w_apply) begin
            if (i_wr) begin
                r_act_div <= i_wr_data;
                r_shd_div <= i_wr_data;
            end else begin
                r_act_div <= r_shd_div;
            end
            r_pending <= 1'b0;
        end else if (i_wr) begin
            r_shd_div <= i_wr_data;
            r_pending <= 1'b1;
        end
    end

    // Counter and output toggle; restart and disable both park the channel
    // at the start of a low half-period so re-enable never makes a runt.
    always_ff @(posedge clk_in) begin
        if (rst || i_restart || !i_en) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (w_wrap) begin
            r_cnt     <= '0;
            r_clk_out <= ~r_clk_out;
            r_tick    <= w_tick_evt;
        end else begin
            r_cnt     <= r_cnt + CNT_W'(1);
            r_tick    <= 1'b0;
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;
    assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_multi
// Description : NUM_CH independent programmable clock dividers with runtime
//               divisor load, glitch-free apply and global phase restart.
//               Macro CLKDIV_RISE_TICK_EN: tick once per output period.
//               CNT_W is limited to 64 bits and NUM_CH to 16.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int                      NUM_CH   = 4,
    parameter int                      CNT_W    = c_CNT_W_DEFAULT,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {NUM_CH{CNT_W'(1)}},
    parameter int                      SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : c_SEL_W_MIN
) (
    input  wire logic       clk_in,
    input  wire logic       rst,
    clk_div_multi_if.slave  bus
);

    // Widened copy so the package helper can slice it at any geometry.
    localparam logic [c_FLAT_W-1:0] c_DIV_FLAT = c_FLAT_W'(DIV_INIT);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam logic [CNT_W-1:0] c_INIT =
            CNT_W'(div_init_slice(c_DIV_FLAT, gi, CNT_W));

        logic w_wr;

        // Out-of-range selects match no channel and are dropped.
        assign w_wr = bus.div_wr && (bus.div_sel == SEL_W'(gi));

        clk_div_chan #(
            .CNT_W    (CNT_W),
            .DIV_INIT (c_INIT)
        ) u_chan (
            .clk_in    (clk_in),
            .rst       (rst),
            .i_en      (bus.ch_en[gi]),
            .i_restart (bus.sync_restart),
            .i_wr      (w_wr),
            .i_wr_data (bus.div_data),
            .o_clk_out (bus.clk_out[gi]),
            .o_tick    (bus.tick[gi]),
            .o_pending (bus.div_pending[gi])
        );
    end

endmodule
`default_nettype wire

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised, multi-channel successor to the fixed-ratio clock divider.
- Each channel produces:
  - a 50%-duty divided square wave, `clk_out`, used as a clock-enable source;
  - a single-cycle strobe, `tick`.
- Each channel has its own divisor, loadable at runtime; all channels can be phase-aligned with a global restart.
- Sits beside the top-level clocking; feeds display refresh, debounce and game-timer logic with programmable rates instead of hard-coded constants.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 32, width of the per-channel counter and divisor.
- DIV_INIT, {NUM_CH{CNT_W'd1}}, flattened reset divisors; channel i uses bits [i*CNT_W +: CNT_W].
- SEL_W, $clog2(NUM_CH) (min 1), derived width of div_sel.

Ports:
- clk_in  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous reset, active-high.
- ch_en  in  NUM_CH  per-channel run enable.
- sync_restart  in  1  global phase-align pulse.
- div_wr  in  1  divisor write strobe.
- div_sel  in  SEL_W  channel index for div_wr.
- div_data  in  CNT_W  divisor value; half-period = div_data+1 clk_in cycles.
- clk_out  out  NUM_CH  divided square waves.
- tick  out  NUM_CH  one-cycle strobes at channel events.
- div_pending  out  NUM_CH  shadow divisor written but not yet applied.

Behaviour:
- Registers per channel:
  - cnt[CNT_W];
  - active divisor act_div;
  - shadow divisor shd_div;
  - pending flag;
  - clk_out bit.
- Reset (rst=1 at a clock edge) sets the following on the next cycle:
  - cnt=0, clk_out=0, tick=0, div_pending=0;
  - act_div=shd_div=DIV_INIT slice.
  - rst overrides all other inputs.
- Counting, when ch_en[i]=1:
  - If cnt==act_div (the "wrap"): cnt<=0, clk_out toggles, tick[i]=1 for that one cycle (registered, asserted the same cycle clk_out changes).
  - Otherwise: cnt<=cnt+1, tick[i]=0.
  - Output period = 2*(act_div+1) clk_in cycles.
  - act_div=0 gives clk_in/2 with tick every cycle.
  - cnt arithmetic is modulo 2^CNT_W; wrap always precedes overflow because act_div < 2^CNT_W.
- Disabled, when ch_en[i]=0:
  - cnt held at 0, clk_out forced 0, tick 0;
  - divisor writes are still accepted;
  - pending is applied immediately, because no wrap is in progress.
- Re-enable:
  - first toggle (0->1) after act_div+1 enabled cycles;
  - no runt pulse.
- Divisor write:
  - div_wr=1 with div_sel<NUM_CH: shd_div[div_sel]<=div_data, pending<=1.
  - div_sel>=NUM_CH: the write is ignored.
- Apply rule: at the channel's next wrap, act_div<=shd_div and pending<=0. A running channel never changes period mid half-cycle (glitch-free).
- Write in the same cycle as a wrap on that channel: div_data is loaded straight into act_div (and shd_div), pending stays 0.
- sync_restart=1:
  - all channels: cnt<=0, clk_out<=0, tick<=0;
  - all pending shadows are applied and pending cleared;
  - an enabled channel's first tick follows act_div+1 cycles after the restart cycle.
  - If div_wr coincides with sync_restart: div_data is applied directly to the addressed channel.
- Priority: rst > sync_restart > div_wr/wrap > count.
- Latency: div_wr to div_pending high is 1 cycle.

Optional Feature:
- Macro: CLKDIV_RISE_TICK_EN.
- Defined: tick[i] asserts only on wraps where clk_out goes 0->1, i.e. once per full output period, 2*(act_div+1) cycles. Divisor apply still occurs at every wrap.
- Undefined: tick asserts on every wrap, i.e. twice per output period.

Decomposition:
- Shared package clk_div_pkg holds:
  - default CNT_W;
  - the helper function extracting DIV_INIT slices;
  - the localparam for minimum SEL_W.
- One sub-module, clk_div_chan, is the natural split:
  - it holds a single channel's cnt, act/shd divisor, pending and toggle logic;
  - the top instantiates NUM_CH copies in a generate loop and decodes div_wr/div_sel into per-channel write strobes.

Test Plan:
- Reset, DIV_INIT all 1, ch_en=4'hF -> clk_out all 0 after reset; each clk_out toggles every 2 cycles (period 4); tick high every 2nd cycle (every 4th with CLKDIV_RISE_TICK_EN).
- Channel 2 running act_div=3; write div_data=0 mid half-period -> div_pending[2]=1 next cycle; period stays 8 until the next wrap, then becomes 2; pending clears at that wrap.
- div_wr to channel 1 in the exact wrap cycle with div_data=5 -> new half-period of 6 starts immediately; div_pending[1] never asserts.
- ch_en[0] dropped mid-count for 10 cycles then raised, act_div=2 -> clk_out[0]=0 while disabled; first rise exactly 3 cycles after re-enable.
- Channels at act_div 1,2,3,4 running; pulse sync_restart -> all clk_out 0 next cycle; first ticks at +2,+3,+4,+5 cycles.
- Edge cases:
  - div_sel=NUM_CH write: no state change.
  - CNT_W=4, act_div=15: period 32, no overflow.
  - rst asserted mid-count: outputs zero next cycle, divisors back to DIV_INIT.
